load_store_unit: RTL

Byte-addressed load/store front end sitting between the CPU memory stage and the word-addressed data RAM (32-bit words, combinational read, write on rising `clk` when write-enable is high). Converts byte/halfword/word requests into RAM word accesses. Extracts and extends load data, and performs read-modify-write for sub-word stores. Handles requests one at a time using a req/busy/done handshake.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 37 +++
 rtl/load_store_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state enum, lane widths and the misalignment rule.
// Imported by lsu_align and load_store_unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Size code 3 is reserved and behaves as a full word.
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    if (is_word(sz))       return (off != 2'd0);
    else if (sz == SZ_HALF) return off[0];
    else                    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends load data from a RAM word and merges
// store data into the addressed byte/halfword lane(s) of that word.
// Purely combinational; halfwords use addr[1] only, words ignore the offset.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_load,
  output logic [WORD_W-1:0] o_merge
);

  logic [BYTE_W-1:0] w_byte;
  logic [HALF_W-1:0] w_half;

  // Select the addressed lane and extend it; merge store data into the same lane.
  always_comb begin
    w_byte  = i_word[{i_off, 3'b000} +: BYTE_W];
    w_half  = i_word[{i_off[1], 4'b0000} +: HALF_W];
    o_load  = i_word;
    o_merge = i_word;
    if (is_word(i_size)) begin
      o_load  = i_word;
      o_merge = i_wdata;
    end else if (i_size == SZ_HALF) begin
      o_load = {{(WORD_W-HALF_W){~i_uns & w_half[HALF_W-1]}}, w_half};
      o_merge[{i_off[1], 4'b0000} +: HALF_W] = i_wdata[HALF_W-1:0];
    end else begin
      o_load = {{(WORD_W-BYTE_W){~i_uns & w_byte[BYTE_W-1]}}, w_byte};
      o_merge[{i_off, 3'b000} +: BYTE_W] = i_wdata[BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end onto a word RAM, with RMW for sub-word stores.
// Latency: load/word store done at T+2, sub-word store T+3, misaligned T+1.
// One request at a time; req is ignored while busy. LSU_MISALIGN_CHECK_EN enables err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  input  logic [AW+1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [WORD_W-1:0] o_rdata,
  output logic [AW-1:0]     o_ram_addr,
  output logic [WORD_W-1:0] o_ram_din,
  output logic              o_ram_we,
  input  logic [WORD_W-1:0] i_ram_dout
);

  lsu_state_t        r_state, w_next;
  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [AW+1:0]     r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_buf;
  logic [WORD_W-1:0] r_rdata;
  logic              w_mis;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_load;
  logic [WORD_W-1:0] w_merge;

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_err;
  assign w_mis = misaligned(i_size, i_addr[1:0]);
  assign o_err = (r_state == ST_DONE) && r_err;
`else
  assign w_mis = 1'b0;
  assign o_err = 1'b0;
`endif

  // In RD the RAM word is live on the bus; afterwards the buffered copy is used.
  assign w_word = (r_state == ST_RD) ? i_ram_dout : r_buf;

  lsu_align u_align (
    .i_word  (w_word),
    .i_off   (r_addr[1:0]),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_merge (w_merge)
  );

  // Next-state and handshake/RAM-control outputs.
  always_comb begin
    w_next    = r_state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_ram_we  = 1'b0;
    o_ram_din = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          if (w_mis)                        w_next = ST_DONE;
          else if (i_wr && is_word(i_size)) w_next = ST_WR;
          else                              w_next = ST_RD;
        end
      end
      ST_RD: begin
        o_busy = 1'b1;
        w_next = r_wr ? ST_WR : ST_DONE;
      end
      ST_WR: begin
        o_busy    = 1'b1;
        o_ram_we  = !i_rst;
        o_ram_din = w_merge;
        w_next    = ST_DONE;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register, request latches, word buffer and load result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_wr    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_req) begin
        r_wr    <= i_wr;
        r_size  <= i_size;
        r_uns   <= i_uns;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
        r_err   <= w_mis;
`endif
      end
      if (r_state == ST_RD) begin
        r_buf <= i_ram_dout;
        if (!r_wr) r_rdata <= w_load;
      end
    end
  end

  assign o_rdata    = r_rdata;
  assign o_ram_addr = r_addr[AW+1:2];

endmodule
